// File: rtl/mul_8bit.sv
// mul_8bit: sequential 8x8 unsigned shift-and-add multiplier.
// Product is truncated to 8 bits and is valid once busy falls.
//
// Ports:
//   clk_i   - clock, all state changes on the rising edge
//   rst_i   - asynchronous active-low reset
//   a_bi    - multiplicand, captured on the start edge
//   b_bi    - multiplier, captured on the start edge
//   start_i - start request, sampled only while idle
//   busy_o  - high while a product is being computed
//   y_bo    - last completed product, (a*b) mod 256

module mul_8bit (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] a_bi,
  input  logic [7:0] b_bi,
  input  logic       start_i,
  output logic       busy_o,
  output logic [7:0] y_bo
);

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [7:0] acc;
  logic [2:0] ctr;
  logic [7:0] acc_nxt;
  logic       last;

  // One partial product per cycle; bits shifted past
  // bit 7 drop out, which gives the mod-256 result.
  always_comb begin
    acc_nxt = acc;
    if (b_r[ctr]) begin
      acc_nxt = acc + (a_r << ctr);
    end
  end

  assign last = (ctr == 3'd7);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      y_bo   <= 8'd0;
      a_r    <= 8'd0;
      b_r    <= 8'd0;
      acc    <= 8'd0;
      ctr    <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            a_r    <= a_bi;
            b_r    <= b_bi;
            acc    <= 8'd0;
            ctr    <= 3'd0;
            busy_o <= 1'b1;
            state  <= WORK;
          end
        end
        WORK: begin
          acc <= acc_nxt;
          ctr <= ctr + 3'd1;
          if (last) begin
            y_bo   <= acc_nxt;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_8bit.sv
// tb_mul_8bit: directed self-checking bench for mul_8bit.
// Each scenario task drives stimulus and checks inline.

module tb_mul_8bit;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] a_bi;
  logic [7:0] b_bi;
  logic       start_i;
  logic       busy_o;
  logic [7:0] y_bo;

  int errors;
  int checks;

  mul_8bit dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_bi    (a_bi),
    .b_bi    (b_bi),
    .start_i (start_i),
    .busy_o  (busy_o),
    .y_bo    (y_bo)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issues one product and checks busy length, the held
  // output during the run, and the final result.
  task automatic run_mul(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] exp,
    input logic [7:0] prev,
    input bit         disturb,
    input string      name
  );
    a_bi    = a;
    b_bi    = b;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy_o !== 1'b1) begin
        errors++;
        $display("FAIL %s busy[%0d]: got %b want 1",
                 name, i, busy_o);
      end
      checks++;
      if (y_bo !== prev) begin
        errors++;
        $display("FAIL %s hold[%0d]: got %0d want %0d",
                 name, i, y_bo, prev);
      end
      if (disturb) begin
        if (i == 1) begin
          a_bi    = 8'd9;
          b_bi    = 8'd9;
          start_i = 1'b1;
        end
        if (i == 3) start_i = 1'b0;
        if (i == 5) start_i = 1'b1;
        if (i == 6) start_i = 1'b0;
      end
      tick();
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_end: got %b want 0",
               name, busy_o);
    end
    checks++;
    if (y_bo !== exp) begin
      errors++;
      $display("FAIL %s result: got %0d want %0d",
               name, y_bo, exp);
    end
  endtask

  task automatic test_reset();
    rst_i   = 1'b0;
    start_i = 1'b0;
    a_bi    = 8'd0;
    b_bi    = 8'd0;
    #3;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset busy: got %b want 0", busy_o);
    end
    checks++;
    if (y_bo !== 8'd0) begin
      errors++;
      $display("FAIL reset y: got %0d want 0", y_bo);
    end
  endtask

  task automatic test_basic();
    a_bi    = 8'd3;
    b_bi    = 8'd5;
    start_i = 1'b1;
    rst_i   = 1'b1;
    run_mul(8'd3, 8'd5, 8'd15, 8'd0, 1'b0, "basic");
  endtask

  task automatic test_trunc();
    run_mul(8'd200, 8'd3, 8'd88, 8'd15, 1'b0, "t200x3");
    run_mul(8'd255, 8'd255, 8'd1, 8'd88, 1'b0, "t255x255");
  endtask

  task automatic test_zero_ident();
    run_mul(8'd0, 8'd77, 8'd0, 8'd1, 1'b0, "zero");
    run_mul(8'd123, 8'd1, 8'd123, 8'd0, 1'b0, "ident");
  endtask

  task automatic test_mid_change();
    run_mul(8'd6, 8'd7, 8'd42, 8'd123, 1'b1, "midchg");
  endtask

  task automatic test_back_to_back();
    a_bi    = 8'd2;
    b_bi    = 8'd3;
    start_i = 1'b1;
    tick();
    a_bi = 8'd10;
    b_bi = 8'd10;
    repeat (8) tick();
    checks++;
    if (busy_o !== 1'b0 || y_bo !== 8'd6) begin
      errors++;
      $display("FAIL b2b first: got busy=%b y=%0d want 0/6",
               busy_o, y_bo);
    end
    tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b restart: got busy=%b want 1",
               busy_o);
    end
    repeat (7) begin
      tick();
      checks++;
      if (busy_o !== 1'b1 || y_bo !== 8'd6) begin
        errors++;
        $display("FAIL b2b hold: got busy=%b y=%0d want 1/6",
                 busy_o, y_bo);
      end
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || y_bo !== 8'd100) begin
      errors++;
      $display("FAIL b2b second: got busy=%b y=%0d want 0/100",
               busy_o, y_bo);
    end
  endtask

  task automatic test_mid_reset();
    a_bi    = 8'd5;
    b_bi    = 8'd5;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst busy: got %b want 0", busy_o);
    end
    checks++;
    if (y_bo !== 8'd0) begin
      errors++;
      $display("FAIL midrst y: got %0d want 0", y_bo);
    end
    #1;
    rst_i = 1'b1;
    run_mul(8'd4, 8'd4, 8'd16, 8'd0, 1'b0, "after_rst");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_trunc();
    test_zero_ident();
    test_mid_change();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
